mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Executes loads and stores against a single-port data-memory bus with a req/ack handshake.
- Formats load data: byte/halfword select, sign/zero extension.
- Raises a stall request while a memory access is outstanding.
- Non-memory instructions pass through in the same cycle.

Parameters:
- ADDR_W, 32, width of the data-bus address.
- TIMEOUT_CYCLES, 255, WAIT-state cycle limit before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_regDest  in  5  destination register from EX/MEM; 0 means no writeback
- ex_value  in  32  ALU result; the effective address for memory ops
- ex_memOp  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
- ex_storeData  in  32  store source register value
- mem_regDest  out  5  to MEM/WB
- mem_value  out  32  to MEM/WB
- stall_req  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misalign_exc  out  1  misaligned access flag (combinational)
- dmem_req  out  1  bus request (registered)
- dmem_we  out  1  write enable (registered)
- dmem_addr  out  ADDR_W  word-aligned address; bits [1:0] = 0 (registered)
- dmem_wdata  out  32  lane-replicated store data (registered)
- dmem_be  out  4  byte enables (registered)
- dmem_rdata  in  32  read data, valid when dmem_ack = 1
- dmem_ack  in  1  one-cycle completion pulse
- bus_err  out  1  timeout abort pulse (MEM_TIMEOUT_EN only; tie 0 otherwise)

Behaviour:
- Byte lanes are little-endian: byte k of a word is bits [8k+7:8k].
- Halfword at addr[1] is bits [16·addr[1]+15 : 16·addr[1]].
- States: IDLE, WAIT, DONE.
- Reset, while rst = 1:
  - state = IDLE.
  - dmem_req/we/addr/wdata/be = 0; rdata_q = 0.
  - mem_regDest = 0, mem_value = 0, stall_req = 0, misalign_exc = 0, bus_err = 0.
- Reset mid-WAIT: abandons the request; dmem_req falls on the next edge. The memory must tolerate this.
- Misalignment rule: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 0.
- IDLE, op NONE: mem_regDest = ex_regDest, mem_value = ex_value, stall_req = 0. Zero added latency.
- IDLE, misaligned mem op:
  - misalign_exc = 1, mem_regDest = 0, mem_value = 0.
  - No bus request, stall_req = 0, state stays IDLE.
- IDLE, aligned mem op:
  - stall_req = 1 combinationally; mem_regDest = 0.
  - At the edge: dmem_req <= 1, dmem_addr <= {ex_value[31:2], 2'b00}, dmem_we <= store, state <= WAIT.
  - Also latched: regDest, op, addr[1:0].
  - Store be: SB = 1 << addr[1:0]; SH = addr[1] ? 4'b1100 : 4'b0011; SW = 4'b1111.
  - Store wdata: byte replicated ×4, or halfword replicated ×2.
  - Load: be = 4'b1111.
- WAIT:
  - stall_req = 1, mem_regDest = 0; dmem_req held with stable addr/we/be/wdata.
  - dmem_ack sampled at the edge. On ack: dmem_req <= 0, rdata_q <= formatted data, state <= DONE.
  - Ack may arrive in the first WAIT cycle.
- Load formatting: LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- DONE:
  - stall_req = 0. MEM/WB captures and EX/MEM advances at this edge.
  - Load: mem_regDest = latched regDest, mem_value = rdata_q.
  - Store: mem_regDest = 0, mem_value = 0.
  - Next state is always IDLE.
- Minimum occupancy: 3 cycles (IDLE issue, WAIT, DONE). Back-to-back memory ops issue from IDLE on the cycle after DONE.
- dmem_ack outside WAIT is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES with no ack: dmem_req <= 0, state <= DONE.
  - In that DONE: writeback suppressed (mem_regDest = 0) and bus_err = 1 for that cycle.
  - Ack on the limit cycle wins over timeout.
- Undefined: no counter; WAIT is held indefinitely; bus_err is constant 0.

Test Plan:
- op NONE, regDest 5'd3, value 32'h1234_5678 -> same-cycle mem_regDest 3, mem_value 32'h1234_5678, stall_req 0.
- LB, addr 32'h0000_0102, ack after 2 WAIT cycles, rdata 32'h11_80_33_44:
  - dmem_addr 32'h100, be 4'hF.
  - DONE mem_value 32'hFFFF_FF80.
  - stall_req high for exactly 3 cycles.
- LHU, addr 32'h6, rdata 32'hBEEF_0000 -> mem_value 32'h0000_BEEF.
- SH, addr 32'h2, data 32'h0000_ABCD, ack in first WAIT -> dmem_we 1, be 4'b1100, wdata 32'hABCD_ABCD; DONE mem_regDest 0.
- LW, addr 32'h5 -> misalign_exc 1, dmem_req stays 0, stall_req 0, mem_regDest 0.
- rst asserted in WAIT -> next cycle dmem_req 0, state IDLE, stall_req 0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES 4, never ack -> bus_err pulse in DONE, mem_regDest 0.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage between the EX/MEM and MEM/WB registers.
//
// Runs loads and stores on a single-port data bus that uses a req/ack handshake.
// It also formats load data (byte or halfword select, sign or zero extension).
// A stall is requested while an access is outstanding.
// Non-memory instructions pass through in the same cycle.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   A WAIT-state watchdog aborts an access that has not been acknowledged after
//   TIMEOUT_CYCLES cycles. It then pulses bus_err and suppresses the writeback.
//   When the macro is undefined, WAIT is held indefinitely and bus_err is tied to 0.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ex_regDest        destination register from EX/MEM (0 = no writeback)
//   ex_value          ALU result / effective address
//   ex_memOp          0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW (9-15 = NONE)
//   ex_storeData      store source register value
//   mem_regDest       destination register to MEM/WB
//   mem_value         result value to MEM/WB
//   stall_req         freeze the upstream pipeline
//   misalign_exc      misaligned access flag (combinational)
//   dmem_req/we/addr/wdata/be   registered data-bus request
//   dmem_rdata        read data, valid with dmem_ack
//   dmem_ack          one-cycle completion pulse
//   bus_err           timeout abort pulse

module mem_access_stage #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ex_regDest,
    input  logic [31:0]       ex_value,
    input  logic [3:0]        ex_memOp,
    input  logic [31:0]       ex_storeData,
    output logic [4:0]        mem_regDest,
    output logic [31:0]       mem_value,
    output logic              stall_req,
    output logic              misalign_exc,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              bus_err
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t state, state_next;

    logic              is_load, is_store, is_mem, misaligned, issue;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [ADDR_W-1:0] aligned_addr;

    logic [4:0]        regdest_q;
    logic [3:0]        op_q;
    logic [1:0]        offset_q;
    logic [31:0]       rdata_q;
    logic              op_q_is_load;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_data;
    logic              timeout_hit;
    logic              abort_q;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timed_out;

    // The counter holds the number of WAIT cycles already spent without ack.
    // The last permitted cycle aborts at its edge unless ack arrives in that same cycle.
    assign timeout_hit = (state == WAIT) && !dmem_ack && (wait_cnt == CNT_LAST);
    assign abort_q     = timed_out;
`else
    assign timeout_hit = 1'b0;
    assign abort_q     = 1'b0;
`endif

    // Word-align the effective address and fit it to the bus width.
    generate
        if (ADDR_W == 32) begin : g_addr_eq
            assign aligned_addr = {ex_value[31:2], 2'b00};
        end else if (ADDR_W > 32) begin : g_addr_wide
            assign aligned_addr = {{(ADDR_W-32){1'b0}}, ex_value[31:2], 2'b00};
        end else begin : g_addr_narrow
            assign aligned_addr = {ex_value[ADDR_W-1:2], 2'b00};
        end
    endgenerate

    // Decode the incoming op.
    // Misalignment only applies to halfword and word accesses.
    always_comb begin
        is_load    = (ex_memOp >= OP_LB) && (ex_memOp <= OP_LW);
        is_store   = (ex_memOp >= OP_SB) && (ex_memOp <= OP_SW);
        is_mem     = is_load || is_store;
        misaligned = 1'b0;
        case (ex_memOp)
            OP_LH, OP_LHU, OP_SH: misaligned = ex_value[0];
            OP_LW, OP_SW:         misaligned = |ex_value[1:0];
            default:              misaligned = 1'b0;
        endcase
        issue = is_mem && !misaligned;
    end

    // Build store lanes: replicate the byte or halfword across the word.
    // Enable only the addressed lanes.
    // A load reads the full word and picks the lane when data returns.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        case (ex_memOp)
            OP_SB: begin
                st_be    = 4'b0001 << ex_value[1:0];
                st_wdata = {4{ex_storeData[7:0]}};
            end
            OP_SH: begin
                st_be    = ex_value[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_storeData[15:0]}};
            end
            OP_SW:   st_wdata = ex_storeData;
            default: st_wdata = 32'd0;
        endcase
    end

    // Select the addressed lane of the returned word and extend it according to the latched op.
    always_comb begin
        case (offset_q)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
        op_q_is_load = (op_q >= OP_LB) && (op_q <= OP_LW);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and MEM/WB outputs.
    // While reset is held, every combinational output is forced to zero.
    // The DONE cycle has no stall, so MEM/WB captures the result at that edge.
    always_comb begin
        state_next   = state;
        mem_regDest  = 5'd0;
        mem_value    = 32'd0;
        stall_req    = 1'b0;
        misalign_exc = 1'b0;
        bus_err      = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        mem_regDest = ex_regDest;
                        mem_value   = ex_value;
                    end else if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        stall_req  = 1'b1;
                        state_next = WAIT;
                    end
                end
                WAIT: begin
                    stall_req = 1'b1;
                    if (dmem_ack || timeout_hit) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    bus_err    = abort_q;
                    if (op_q_is_load && !abort_q) begin
                        mem_regDest = regdest_q;
                        mem_value   = rdata_q;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus request registers and the access context latched at issue.
    // The request fields stay stable through WAIT.
    // Only dmem_req drops on completion, abort or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 32'd0;
            dmem_be    <= 4'd0;
            rdata_q    <= 32'd0;
            regdest_q  <= 5'd0;
            op_q       <= 4'd0;
            offset_q   <= 2'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
            timed_out  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= aligned_addr;
                        dmem_wdata <= st_wdata;
                        dmem_be    <= st_be;
                        regdest_q  <= ex_regDest;
                        op_q       <= ex_memOp;
                        offset_q   <= ex_value[1:0];
`ifdef MEM_TIMEOUT_EN
                        wait_cnt   <= '0;
                        timed_out  <= 1'b0;
`endif
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        rdata_q  <= ld_data;
                    end else begin
`ifdef MEM_TIMEOUT_EN
                        wait_cnt <= wait_cnt + 1'b1;
                        if (timeout_hit) begin
                            dmem_req  <= 1'b0;
                            timed_out <= 1'b1;
                        end
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: self-checking bench for mem_access_stage.
//
// The bench checks single-cycle IDLE behaviour from one table.
// It runs complete bus transactions from a second table.
// It also runs directed sequences: reset, reset in WAIT, and a long WAIT or the timeout.
// The DUT is built with TIMEOUT_CYCLES = 4.
// The timeout sequence applies when MEM_TIMEOUT_EN is defined.

`timescale 1ns/1ps

module tb_mem_access_stage;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  ex_regDest = 5'd0;
    logic [31:0] ex_value = 32'd0;
    logic [3:0]  ex_memOp = 4'd0;
    logic [31:0] ex_storeData = 32'd0;
    logic [4:0]  mem_regDest;
    logic [31:0] mem_value;
    logic        stall_req;
    logic        misalign_exc;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;
    logic        bus_err;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clk = ~clk;

    mem_access_stage #(
        .ADDR_W(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_regDest(ex_regDest),
        .ex_value(ex_value),
        .ex_memOp(ex_memOp),
        .ex_storeData(ex_storeData),
        .mem_regDest(mem_regDest),
        .mem_value(mem_value),
        .stall_req(stall_req),
        .misalign_exc(misalign_exc),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be),
        .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .bus_err(bus_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [4:0]  exp_rd;
        logic [31:0] exp_value;
        logic        exp_misalign;
    } idle_vec_t;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] store_data;
        logic [31:0] rdata;
        int          waits;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [4:0]  exp_rd;
        logic [31:0] exp_value;
    } txn_vec_t;

    idle_vec_t idle_vecs[9];
    txn_vec_t  txn_vecs[10];

    // Drive one set of EX/MEM inputs at the falling edge.
    // Then settle so that outputs can be sampled well before the next rising edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] rd,
                                 input logic [31:0] value, input logic [31:0] sd);
        @(negedge clk);
        ex_memOp     = op;
        ex_regDest   = rd;
        ex_value     = value;
        ex_storeData = sd;
        dmem_ack     = 1'b0;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Issue one access, acknowledge it in WAIT cycle number 'waits', and check the DONE cycle.
    task automatic runTxn(input txn_vec_t t, input int idx);
        int stall_cycles;
        string pfx;
        pfx = $sformatf("txn%0d", idx);
        applyStimulus(t.op, t.rd, t.addr, t.store_data);
        checkOutput({pfx, "_issue_stall"}, stall_req, 1);
        checkOutput({pfx, "_issue_rd"}, mem_regDest, 0);
        stall_cycles = 1;
        for (int w = 0; w < t.waits; w++) begin
            @(negedge clk);
            dmem_ack   = (w == t.waits - 1);
            dmem_rdata = (w == t.waits - 1) ? t.rdata : 32'hA5A5_5A5A;
            #2;
            if (w == 0) begin
                checkOutput({pfx, "_req"}, dmem_req, 1);
                checkOutput({pfx, "_addr"}, dmem_addr, t.exp_addr);
                checkOutput({pfx, "_be"}, dmem_be, t.exp_be);
                checkOutput({pfx, "_we"}, dmem_we, t.exp_we);
                if (t.exp_we) checkOutput({pfx, "_wdata"}, dmem_wdata, t.exp_wdata);
            end
            if (stall_req) stall_cycles++;
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h5A5A_A5A5;
        #2;
        checkOutput({pfx, "_stall_len"}, stall_cycles, t.waits + 1);
        checkOutput({pfx, "_done_stall"}, stall_req, 0);
        checkOutput({pfx, "_done_req"}, dmem_req, 0);
        checkOutput({pfx, "_done_rd"}, mem_regDest, t.exp_rd);
        checkOutput({pfx, "_done_value"}, mem_value, t.exp_value);
    endtask

    initial begin
        int stall_cycles;
        int err_cycles;

        idle_vecs[0] = '{OP_NONE, 5'd3,  32'h1234_5678, 5'd3,  32'h1234_5678, 1'b0};
        idle_vecs[1] = '{4'd9,    5'd17, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFF, 1'b0};
        idle_vecs[2] = '{4'd15,   5'd0,  32'h0000_0000, 5'd0,  32'h0000_0000, 1'b0};
        idle_vecs[3] = '{OP_LW,   5'd8,  32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1};
        idle_vecs[4] = '{OP_LH,   5'd9,  32'h0000_0003, 5'd0,  32'h0000_0000, 1'b1};
        idle_vecs[5] = '{OP_LHU,  5'd10, 32'h0000_0101, 5'd0,  32'h0000_0000, 1'b1};
        idle_vecs[6] = '{OP_SH,   5'd11, 32'h0000_0007, 5'd0,  32'h0000_0000, 1'b1};
        idle_vecs[7] = '{OP_SW,   5'd12, 32'h0000_0002, 5'd0,  32'h0000_0000, 1'b1};
        idle_vecs[8] = '{OP_LW,   5'd13, 32'h0000_0006, 5'd0,  32'h0000_0000, 1'b1};

        txn_vecs[0] = '{OP_LB,  5'd7,  32'h0000_0102, 32'h0,         32'h1180_3344, 2,
                        32'h0000_0100, 4'hF, 1'b0, 32'h0,         5'd7,  32'hFFFF_FF80};
        txn_vecs[1] = '{OP_LHU, 5'd9,  32'h0000_0006, 32'h0,         32'hBEEF_0000, 1,
                        32'h0000_0004, 4'hF, 1'b0, 32'h0,         5'd9,  32'h0000_BEEF};
        txn_vecs[2] = '{OP_SH,  5'd4,  32'h0000_0002, 32'h0000_ABCD, 32'h0,         1,
                        32'h0000_0000, 4'hC, 1'b1, 32'hABCD_ABCD, 5'd0,  32'h0};
        txn_vecs[3] = '{OP_LBU, 5'd1,  32'h0000_0203, 32'h0,         32'h8000_0000, 3,
                        32'h0000_0200, 4'hF, 1'b0, 32'h0,         5'd1,  32'h0000_0080};
        txn_vecs[4] = '{OP_LH,  5'd2,  32'h0000_0010, 32'h0,         32'h1234_8001, 1,
                        32'h0000_0010, 4'hF, 1'b0, 32'h0,         5'd2,  32'hFFFF_8001};
        txn_vecs[5] = '{OP_LW,  5'd31, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D, 2,
                        32'hFFFF_FFFC, 4'hF, 1'b0, 32'h0,         5'd31, 32'hCAFE_F00D};
        txn_vecs[6] = '{OP_SB,  5'd5,  32'h0000_0031, 32'h1234_56A7, 32'h0,         2,
                        32'h0000_0030, 4'h2, 1'b1, 32'hA7A7_A7A7, 5'd0,  32'h0};
        txn_vecs[7] = '{OP_SW,  5'd6,  32'h0000_0040, 32'hDEAD_BEEF, 32'h0,         1,
                        32'h0000_0040, 4'hF, 1'b1, 32'hDEAD_BEEF, 5'd0,  32'h0};
        txn_vecs[8] = '{OP_LB,  5'd0,  32'h0000_0001, 32'h0,         32'h0000_7F00, 1,
                        32'h0000_0000, 4'hF, 1'b0, 32'h0,         5'd0,  32'h0000_007F};
        txn_vecs[9] = '{OP_SH,  5'd14, 32'h0000_0000, 32'hFFFF_1234, 32'h0,         3,
                        32'h0000_0000, 4'h3, 1'b1, 32'h1234_1234, 5'd0,  32'h0};

        $display("[TB] start");

        // Reset state: the outputs stay zero even with a pass-through op applied.
        rst = 1'b1;
        applyStimulus(OP_NONE, 5'd3, 32'h1234_5678, 32'h0);
        applyStimulus(OP_NONE, 5'd3, 32'h1234_5678, 32'h0);
        checkOutput("rst_rd", mem_regDest, 0);
        checkOutput("rst_value", mem_value, 0);
        checkOutput("rst_stall", stall_req, 0);
        checkOutput("rst_misalign", misalign_exc, 0);
        checkOutput("rst_bus_err", bus_err, 0);
        checkOutput("rst_req", dmem_req, 0);
        checkOutput("rst_be", dmem_be, 0);
        checkOutput("rst_addr", dmem_addr, 0);
        rst = 1'b0;

        // Single-cycle IDLE behaviour: pass-through and misalignment.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(idle_vecs[i].op, idle_vecs[i].rd, idle_vecs[i].value, 32'hFFFF_FFFF);
            checkOutput($sformatf("idle%0d_rd", i), mem_regDest, idle_vecs[i].exp_rd);
            checkOutput($sformatf("idle%0d_value", i), mem_value, idle_vecs[i].exp_value);
            checkOutput($sformatf("idle%0d_stall", i), stall_req, 0);
            checkOutput($sformatf("idle%0d_misalign", i), misalign_exc, idle_vecs[i].exp_misalign);
            checkOutput($sformatf("idle%0d_req", i), dmem_req, 0);
        end
        applyStimulus(OP_NONE, 5'd0, 32'h0, 32'h0);
        checkOutput("misalign_no_req", dmem_req, 0);

        // An ack while IDLE is ignored and produces no request.
        applyStimulus(OP_NONE, 5'd2, 32'h0000_0042, 32'h0);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        #2;
        checkOutput("idle_ack_req", dmem_req, 0);
        checkOutput("idle_ack_rd", mem_regDest, 2);

        // Full transactions, each issued on the cycle after the previous DONE.
        for (int i = 0; i < 10; i++) begin
            runTxn(txn_vecs[i], i);
        end

        // Reset during WAIT abandons the request.
        applyStimulus(OP_LW, 5'd12, 32'h0000_0080, 32'h0);
        @(negedge clk);
        #2;
        checkOutput("rstwait_req_before", dmem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("rstwait_stall_in_rst", stall_req, 0);
        @(negedge clk);
        rst = 1'b0;
        ex_memOp   = OP_NONE;
        ex_regDest = 5'd3;
        ex_value   = 32'h1234_5678;
        #2;
        checkOutput("rstwait_req_after", dmem_req, 0);
        checkOutput("rstwait_stall_after", stall_req, 0);
        checkOutput("rstwait_idle_rd", mem_regDest, 3);
        checkOutput("rstwait_idle_value", mem_value, 32'h1234_5678);

`ifdef MEM_TIMEOUT_EN
        // Timeout: with no ack, WAIT lasts four cycles and DONE flags bus_err.
        applyStimulus(OP_LW, 5'd10, 32'h0000_0020, 32'h0);
        stall_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (!stall_req) break;
            stall_cycles++;
        end
        checkOutput("tmo_wait_cycles", stall_cycles, 4);
        checkOutput("tmo_bus_err", bus_err, 1);
        checkOutput("tmo_rd", mem_regDest, 0);
        checkOutput("tmo_req", dmem_req, 0);
        applyStimulus(OP_NONE, 5'd0, 32'h0, 32'h0);
        checkOutput("tmo_bus_err_pulse", bus_err, 0);

        // An ack on the limit cycle takes priority over the timeout.
        applyStimulus(OP_LW, 5'd11, 32'h0000_0024, 32'h0);
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            dmem_ack   = (w == 3);
            dmem_rdata = 32'h0000_600D;
        end
        @(negedge clk);
        dmem_ack = 1'b0;
        #2;
        checkOutput("tmo_ack_bus_err", bus_err, 0);
        checkOutput("tmo_ack_rd", mem_regDest, 11);
        checkOutput("tmo_ack_value", mem_value, 32'h0000_600D);
`else
        // Without the watchdog, WAIT holds indefinitely until an ack arrives.
        applyStimulus(OP_LW, 5'd10, 32'h0000_0020, 32'h0);
        stall_cycles = 0;
        err_cycles   = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            if (stall_req && dmem_req) stall_cycles++;
            if (bus_err) err_cycles++;
        end
        checkOutput("longwait_held", stall_cycles, 20);
        checkOutput("longwait_bus_err", err_cycles, 0);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0055;
        @(negedge clk);
        dmem_ack = 1'b0;
        #2;
        checkOutput("longwait_done_rd", mem_regDest, 10);
        checkOutput("longwait_done_value", mem_value, 32'h0000_0055);
        checkOutput("longwait_done_bus_err", bus_err, 0);
`endif

        applyStimulus(OP_NONE, 5'd0, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
